// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arms on request, waits for a trigger level, then drives
// FIFO writes until the latched sample count is reached or the FIFO reports full.
module adc_capture_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 trigger_i,
  input  logic                 trigger_mode_i,
  input  logic                 trigger_wait_i,
  input  logic [CNT_WIDTH-1:0] sample_count_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_wr_en_o,
  output logic                 armed_o,
  output logic                 capturing_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] samples_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INACTIVE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] count_lat;
  logic [CNT_WIDTH-1:0] timeout_lat;
  logic [CNT_WIDTH-1:0] timeout_cnt;
  logic [CNT_WIDTH-1:0] samples_inc;
  logic                 trig_active;

  assign trig_active = (trigger_i == trigger_mode_i);
  // Free-running capture (count 0) must pin at all-ones rather than wrap.
  assign samples_inc = (&samples_o) ? samples_o : samples_o + CNT_WIDTH'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= S_IDLE;
      count_lat    <= '0;
      timeout_lat  <= '0;
      timeout_cnt  <= '0;
      fifo_wr_en_o <= 1'b0;
      armed_o      <= 1'b0;
      capturing_o  <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
      samples_o    <= '0;
    end else if (abort_i) begin
      state        <= S_IDLE;
      fifo_wr_en_o <= 1'b0;
      armed_o      <= 1'b0;
      capturing_o  <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            count_lat   <= sample_count_i;
            timeout_lat <= timeout_i;
            timeout_cnt <= '0;
            samples_o   <= '0;
            timeout_o   <= 1'b0;
            done_o      <= 1'b0;
            if (trigger_wait_i) begin
              state <= S_WAIT_INACTIVE;
            end else begin
              state   <= S_ARMED;
              armed_o <= 1'b1;
            end
          end
        end
        S_WAIT_INACTIVE: begin
          if (!trig_active) begin
            state   <= S_ARMED;
            armed_o <= 1'b1;
          end
        end
        S_ARMED: begin
          // Trigger is checked first so it beats a timeout landing on the same cycle.
          if (trig_active) begin
            armed_o <= 1'b0;
            if (fifo_full_i) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              samples_o <= '0;
            end else begin
              state        <= S_CAPTURE;
              capturing_o  <= 1'b1;
              fifo_wr_en_o <= 1'b1;
            end
          end else if ((timeout_lat != '0) && (timeout_cnt == timeout_lat - CNT_WIDTH'(1))) begin
            state     <= S_IDLE;
            armed_o   <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
          end
        end
        S_CAPTURE: begin
          if (fifo_full_i) begin
            state        <= S_DONE;
            fifo_wr_en_o <= 1'b0;
            capturing_o  <= 1'b0;
            done_o       <= 1'b1;
          end else begin
            samples_o <= samples_inc;
            if ((count_lat != '0) && (samples_inc == count_lat)) begin
              state        <= S_DONE;
              fifo_wr_en_o <= 1'b0;
              capturing_o  <= 1'b0;
              done_o       <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          fifo_wr_en_o <= 1'b0;
          armed_o      <= 1'b0;
          capturing_o  <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: a cycle table, directed corner sequences, then random
// traffic compared against a behavioural model of the capture rules.
module tb_adc_capture_ctrl;
  localparam int W    = 8;
  localparam int SMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n, arm, abort, trig, mode, wt, full;
  logic [W-1:0] cnt, tmo;
  logic         wr, armed, cap, done, tout;
  logic [W-1:0] samples;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.CNT_WIDTH(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .arm_i(arm), .abort_i(abort),
    .trigger_i(trig), .trigger_mode_i(mode), .trigger_wait_i(wt),
    .sample_count_i(cnt), .timeout_i(tmo), .fifo_full_i(full),
    .fifo_wr_en_o(wr), .armed_o(armed), .capturing_o(cap), .done_o(done),
    .timeout_o(tout), .samples_o(samples)
  );

  typedef struct {
    logic arm, abort, trig, wt, full;
    logic [W-1:0] cnt, tmo;
    logic [4:0] flags;  // {wr, armed, cap, done, tout}
    logic [W-1:0] s;
  } vec_t;

  function automatic vec_t mk(bit a, bit ab, bit tr, bit w, bit fu, int c, int t, bit [4:0] f, int s);
    vec_t v;
    v.arm = a; v.abort = ab; v.trig = tr; v.wt = w; v.full = fu;
    v.cnt = W'(c); v.tmo = W'(t); v.flags = f; v.s = W'(s);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    arm = 0; abort = 0; trig = 0; mode = 1; wt = 0; full = 0;
  endtask

  // Behavioural model: phase name plus countdown/remaining bookkeeping.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ARMED = 2, PH_CAP = 3, PH_DONE = 4;
  int m_ph, m_samples, m_cnt, m_tmo, m_left;
  bit m_tout, m_wr;

  task automatic model_reset();
    m_ph = PH_IDLE; m_samples = 0; m_cnt = 0; m_tmo = 0; m_left = 0; m_tout = 0; m_wr = 0;
  endtask

  task automatic model_step(input bit a, input bit ab, input bit tr, input bit md, input bit w,
                            input int c, input int t, input bit fu);
    bit act;
    act = (tr == md);
    if (ab) begin
      m_ph = PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE, PH_DONE:
          if (a) begin
            m_cnt = c; m_tmo = t; m_left = t; m_samples = 0; m_tout = 0;
            m_ph = w ? PH_WAIT : PH_ARMED;
          end
        PH_WAIT:
          if (!act) m_ph = PH_ARMED;
        PH_ARMED:
          if (act) begin
            if (fu) begin m_ph = PH_DONE; m_samples = 0; end
            else m_ph = PH_CAP;
          end else if (m_tmo != 0) begin
            if (m_left == 1) begin m_ph = PH_IDLE; m_tout = 1; end
            else m_left--;
          end
        PH_CAP:
          if (fu) m_ph = PH_DONE;
          else begin
            m_samples = (m_samples + 1 > SMAX) ? SMAX : m_samples + 1;
            if (m_cnt != 0 && m_samples == m_cnt) m_ph = PH_DONE;
          end
        default: m_ph = PH_IDLE;
      endcase
    end
    m_wr = (m_ph == PH_CAP);
  endtask

  vec_t tbl[20];
  int   n_wr, n_armed;

  initial begin
    tbl[0]  = mk(1,0,0,0,0, 3,0, 5'b01000, 0);
    tbl[1]  = mk(0,0,0,0,0, 3,0, 5'b01000, 0);
    tbl[2]  = mk(0,0,1,0,0, 3,0, 5'b10100, 0);
    tbl[3]  = mk(0,0,0,0,0, 3,0, 5'b10100, 1);
    tbl[4]  = mk(0,0,0,0,0, 3,0, 5'b10100, 2);
    tbl[5]  = mk(0,0,0,0,0, 3,0, 5'b00010, 3);
    tbl[6]  = mk(0,0,0,0,0, 3,0, 5'b00010, 3);
    tbl[7]  = mk(1,0,1,1,0, 2,5, 5'b00000, 0);
    tbl[8]  = mk(0,0,1,0,0, 2,5, 5'b00000, 0);
    tbl[9]  = mk(0,0,0,0,0, 2,5, 5'b01000, 0);
    tbl[10] = mk(0,0,0,0,0, 2,5, 5'b01000, 0);
    tbl[11] = mk(0,0,1,0,1, 2,5, 5'b00010, 0);
    tbl[12] = mk(1,0,0,0,0, 2,2, 5'b01000, 0);
    tbl[13] = mk(0,0,0,0,0, 2,2, 5'b01000, 0);
    tbl[14] = mk(0,0,0,0,0, 2,2, 5'b00001, 0);
    tbl[15] = mk(1,1,0,0,0, 2,2, 5'b00001, 0);
    tbl[16] = mk(1,0,0,0,0, 4,3, 5'b01000, 0);
    tbl[17] = mk(0,0,1,0,0, 4,3, 5'b10100, 0);
    tbl[18] = mk(0,0,0,0,0, 4,3, 5'b10100, 1);
    tbl[19] = mk(0,1,0,0,0, 4,3, 5'b00000, 1);

    idle_in(); cnt = '0; tmo = '0; reset_n = 0;
    tick(); tick();
    chk("reset_state", {19'd0, wr, armed, cap, done, tout, samples}, 32'd0);
    reset_n = 1;

    for (int i = 0; i < 20; i++) begin
      arm = tbl[i].arm; abort = tbl[i].abort; trig = tbl[i].trig; wt = tbl[i].wt;
      full = tbl[i].full; cnt = tbl[i].cnt; tmo = tbl[i].tmo;
      tick();
      chk($sformatf("vec[%0d]", i), {19'd0, wr, armed, cap, done, tout, samples},
          {19'd0, tbl[i].flags, tbl[i].s});
    end

    // Count 8, trigger five cycles after arming.
    idle_in(); cnt = 8; tmo = 0; arm = 1;
    tick(); arm = 0;
    chk("c8_armed", armed, 1);
    repeat (4) tick();
    trig = 1; tick(); trig = 0;
    chk("c8_wr_latency", wr, 1);
    n_wr = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr) n_wr++;
      tick();
    end
    chk("c8_wr_cycles", n_wr, 8);
    chk("c8_done", done, 1);
    chk("c8_samples", samples, 8);

    // Timeout of 20 with no trigger.
    cnt = 5; tmo = 20; arm = 1; n_wr = 0; n_armed = 0;
    for (int i = 0; i < 25; i++) begin
      tick(); arm = 0;
      if (armed) n_armed++;
      if (wr) n_wr++;
    end
    chk("tmo_armed_cycles", n_armed, 20);
    chk("tmo_flag", tout, 1);
    chk("tmo_no_writes", n_wr, 0);

    // Free-running capture stopped by FIFO full after 100 writes.
    cnt = 0; tmo = 0; arm = 1; tick(); arm = 0;
    trig = 1; tick(); trig = 0;
    repeat (100) tick();
    chk("full_pre_samples", samples, 100);
    chk("full_pre_wr", wr, 1);
    full = 1; tick(); full = 0;
    chk("full_wr_drop", wr, 0);
    chk("full_done", done, 1);
    chk("full_samples", samples, 100);

    // Re-arm straight out of DONE with count 4.
    cnt = 4; arm = 1; tick(); arm = 0;
    chk("rearm_cleared", samples, 0);
    chk("rearm_armed", armed, 1);
    trig = 1; tick(); trig = 0;
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      if (wr) n_wr++;
      tick();
    end
    chk("rearm_writes", n_wr, 4);
    chk("rearm_samples", samples, 4);
    chk("rearm_done", done, 1);

    // Saturation with count 0 and a FIFO that never fills.
    cnt = 0; arm = 1; tick(); arm = 0;
    trig = 1; tick(); trig = 0;
    repeat (300) tick();
    chk("sat_samples", samples, SMAX);
    chk("sat_still_capturing", {wr, cap}, 2'b11);
    abort = 1; tick(); abort = 0;
    chk("sat_abort", {19'd0, wr, armed, cap, done, tout, samples}, {19'd0, 5'b00000, 8'(SMAX)});

    // Abort after three writes, then an asynchronous reset mid-capture.
    cnt = 10; arm = 1; tick(); arm = 0;
    trig = 1; tick(); trig = 0;
    repeat (3) tick();
    chk("abort_pre_samples", samples, 3);
    abort = 1; tick(); abort = 0;
    chk("abort_outputs", {19'd0, wr, armed, cap, done, tout, samples}, {19'd0, 5'b00000, 8'd3});
    arm = 1; tick(); arm = 0;
    trig = 1; tick(); trig = 0;
    repeat (2) tick();
    chk("rst_pre_wr", wr, 1);
    #2 reset_n = 0;
    #1 chk("async_reset", {19'd0, wr, armed, cap, done, tout, samples}, 32'd0);
    tick(); tick();
    reset_n = 1;

    // Random traffic against the model.
    model_reset();
    idle_in();
    for (int c = 0; c < 4000; c++) begin
      arm   = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) trig = ~trig;
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      wt    = 1'($urandom_range(0, 1));
      full  = ($urandom_range(0, 19) == 0);
      cnt   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 12));
      tmo   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 15));
      model_step(arm, abort, trig, mode, wt, int'(cnt), int'(tmo), full);
      tick();
      chk($sformatf("rand cyc %0d", c), {19'd0, wr, armed, cap, done, tout, samples},
          {19'd0, m_wr, m_ph == PH_ARMED, m_ph == PH_CAP, m_ph == PH_DONE, m_tout, 8'(m_samples)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
